// File: rtl/program_loader.sv
// rtl/program_loader.sv - streams a program image into CPU RAM over the shared bus while holding the CPU in reset
// Optional trailing-checksum verification is enabled by defining PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
   parameter int RAM_BYTES = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load_start,
   input  logic       load_abort,
   input  logic [7:0] byte_in,
   input  logic       byte_valid,
   output logic       byte_ready,
   output logic [7:0] bus_out,
   output logic       bus_oe,
   output logic       n_load_addr,
   output logic       n_load_data,
   output logic       ram_write_n,
   output logic       cpu_hold,
   output logic       busy,
   output logic       done,
   output logic       err
);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
   typedef enum logic [2:0] {
      IDLE, WAIT_BYTE, DRV_ADDR, DRV_DATA, WRITE, WAIT_SUM, DONE
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE, WAIT_BYTE, DRV_ADDR, DRV_DATA, WRITE, DONE
   } state_t;
`endif

   localparam logic [3:0] LAST_ADDR = 4'(RAM_BYTES - 1);

   state_t     state;
   state_t     state_nxt;
   logic [3:0] addr;
   logic [7:0] byte_q;
   logic       abort_hit;
   logic       sum_fail;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
   logic [7:0] sum;
   logic [7:0] sum_chk;
   assign sum_chk  = sum + byte_in;
   assign sum_fail = (state == WAIT_SUM) && byte_valid && !load_abort && (sum_chk != 8'h00);
`else
   assign sum_fail = 1'b0;
`endif

   assign abort_hit = load_abort && (state != IDLE);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (load_start) state_nxt = WAIT_BYTE;
         WAIT_BYTE: if (byte_valid) state_nxt = DRV_ADDR;
         DRV_ADDR:  state_nxt = DRV_DATA;
         DRV_DATA:  state_nxt = WRITE;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         WRITE:     state_nxt = (addr == LAST_ADDR) ? WAIT_SUM : WAIT_BYTE;
         WAIT_SUM:  if (byte_valid) state_nxt = (sum_chk == 8'h00) ? DONE : IDLE;
`else
         WRITE:     state_nxt = (addr == LAST_ADDR) ? DONE : WAIT_BYTE;
`endif
         DONE:      state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
      // Abort outranks any handshake completing in the same cycle
      if (abort_hit) state_nxt = IDLE;
   end

   // Outputs are registered from the next state so they track the state register exactly
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         addr        <= 4'd0;
         byte_q      <= 8'd0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         sum         <= 8'd0;
`endif
         cpu_hold    <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         byte_ready  <= 1'b0;
         bus_out     <= 8'd0;
         bus_oe      <= 1'b0;
         n_load_addr <= 1'b1;
         n_load_data <= 1'b1;
         ram_write_n <= 1'b1;
         busy        <= 1'b0;
      end else begin
         state <= state_nxt;

         if (state == IDLE && load_start) begin
            addr     <= 4'd0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum      <= 8'd0;
`endif
            done     <= 1'b0;
            err      <= 1'b0;
            cpu_hold <= 1'b1;
         end

         if (state == WAIT_BYTE && byte_valid && !load_abort) begin
            byte_q <= byte_in;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum    <= sum + byte_in;
`endif
         end

         if (state == WRITE && addr != LAST_ADDR && !load_abort)
            addr <= addr + 4'd1;

         if (abort_hit || sum_fail)
            err <= 1'b1;

         if (state_nxt == DONE) begin
            done     <= 1'b1;
            cpu_hold <= 1'b0;
         end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
         byte_ready  <= (state_nxt == WAIT_BYTE) || (state_nxt == WAIT_SUM);
`else
         byte_ready  <= (state_nxt == WAIT_BYTE);
`endif
         bus_oe      <= (state_nxt == DRV_ADDR) || (state_nxt == DRV_DATA);
         bus_out     <= (state_nxt == DRV_ADDR) ? {4'b0000, addr} :
                        (state_nxt == DRV_DATA) ? byte_q : 8'd0;
         n_load_addr <= (state_nxt != DRV_ADDR);
         n_load_data <= (state_nxt != DRV_DATA);
         ram_write_n <= (state_nxt != WRITE);
         busy        <= (state_nxt != IDLE) && (state_nxt != DONE);
      end
   end

endmodule
